pipe_stage_skid: RTL



---
 rtl/pipe_stage_skid.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register: control + payload, valid/ready, optional one-entry skid.
// Latency 1 cycle; SKID=1 registers in_ready and absorbs one stall, SKID=0 passes out_ready through.
module pipe_stage_skid #(
    parameter int               CTRL_W      = 8,
    parameter int               DATA_W      = 80,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter bit               SKID        = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              in_fire, out_fire;
    logic              ld_main_in, ld_main_skid, ld_skid, clr_main;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (in_fire) state_d = ONE;
                ONE: begin
                    if (in_fire && !out_fire)      state_d = TWO;
                    else if (!in_fire && out_fire) state_d = EMPTY;
                end
                TWO:     if (out_fire) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        clr_main     = 1'b0;
        out_valid    = (state_q != EMPTY);
        occupancy    = 2'd0;
        case (state_q)
            EMPTY: begin
                ld_main_in = in_fire;
            end
            ONE: begin
                occupancy  = 2'd1;
                ld_main_in = in_fire & out_fire;
                ld_skid    = in_fire & ~out_fire;
                clr_main   = ~in_fire & out_fire;
            end
            TWO: begin
                occupancy    = 2'd2;
                ld_main_skid = out_fire;
            end
            default: ;
        endcase
    end

    generate
        if (SKID) begin : g_skid_rdy
            // Computed from next state so in_ready never depends on out_ready combinationally.
            logic in_ready_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != TWO);
                end
            end
            assign in_ready = in_ready_q;
        end else begin : g_pass_rdy
            assign in_ready = (state_q == EMPTY) | out_ready;
        end
    endgenerate

    // Payload is never cleared after reset; only ctrl is forced to a bubble so decoders stay safe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_ctrl <= CTRL_BUBBLE;
            main_data <= '0;
            skid_ctrl <= CTRL_BUBBLE;
            skid_data <= '0;
        end else if (flush) begin
            main_ctrl <= CTRL_BUBBLE;
            skid_ctrl <= CTRL_BUBBLE;
        end else begin
            if (ld_main_in) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end else if (ld_main_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end else if (clr_main) begin
                main_ctrl <= CTRL_BUBBLE;
            end
            if (ld_skid) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
        end
    end

    assign out_ctrl = main_ctrl;
    assign out_data = main_data;

endmodule
